// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   NUM_REG / ADDR_W / DATA_W : geometry of the 8x32 register bank
//   CNT_W                     : width of the optional per-requester grant counters
//   state_t                   : arbiter FSM states
package rfarb_pkg;

  localparam int unsigned NUM_REG = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write handshake bundle, one slice per requester.
//   req_valid [NUM_REQ]         requester i holds a write
//   req_addr  [NUM_REQ*ADDR_W]  slice i = target register of requester i
//   req_data  [NUM_REQ*DATA_W]  slice i = write data of requester i
//   req_ready [NUM_REQ]         one-hot grant from the arbiter
// Modports: master = requesters, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ*rfarb_pkg::ADDR_W-1:0] req_addr;
  logic [NUM_REQ*rfarb_pkg::DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]                   req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    [NUM_REQ] request vector
//   ptr    [PTR_W]   highest-priority index for this cycle
//   grant  [NUM_REQ] one-hot grant (all-0 when no request)
//   winner [PTR_W]   index of the granted request (0 when none)
// The winner is the first set request at or after ptr, searching upward
// modulo NUM_REQ.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   winner
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 8x32 register bank.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req_bus   requester handshake bundle (slave modport)
//   clr_req   pulse: start a bank-wide clear (regs 0..7 written with 0)
//   busy      high while the clear sequence runs
//   clr_done  1-cycle pulse alongside the last clear write
//   rf_en     registered one-hot write enable to the bank
//   rf_d_in   registered write data to the bank
//   grant_cnt per-requester saturating handshake counters, 16 bits each
//             (present only when RFARB_STATS_EN is defined)
module regfile_wr_arbiter
  import rfarb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  regfile_wr_arbiter_if.slave       req_bus,
  input  logic                      clr_req,
`ifdef RFARB_STATS_EN
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt,
`endif
  output logic                      busy,
  output logic                      clr_done,
  output logic [NUM_REG-1:0]        rf_en,
  output logic [DATA_W-1:0]         rf_d_in
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic [PTR_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]    winner;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  ready;
  logic                hs;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REG-1:0]  rf_en_nxt;
  logic [DATA_W-1:0]   rf_d_nxt;
  logic                clr_done_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req_bus.req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  // Ready is suppressed during reset, outside IDLE, and when a clear
  // request takes priority in the same cycle.
  assign ready             = (reset_n && (state == IDLE) && !clr_req) ? grant : '0;
  assign req_bus.req_ready = ready;
  assign hs                = |ready;
  assign win_addr          = req_bus.req_addr[32'(winner)*ADDR_W +: ADDR_W];
  assign win_data          = req_bus.req_data[32'(winner)*DATA_W +: DATA_W];
  assign busy              = (state == CLEAR);

  always_comb begin
    state_nxt    = state;
    clr_cnt_nxt  = clr_cnt;
    rr_ptr_nxt   = rr_ptr;
    rf_en_nxt    = '0;
    rf_d_nxt     = rf_d_in;
    clr_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end else if (hs) begin
          rf_en_nxt  = NUM_REG'(1) << win_addr;
          rf_d_nxt   = win_data;
          rr_ptr_nxt = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
      end
      CLEAR: begin
        rf_en_nxt   = NUM_REG'(1) << clr_cnt;
        rf_d_nxt    = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_W'(NUM_REG - 1)) begin
          clr_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      rr_ptr   <= '0;
      rf_en    <= '0;
      rf_d_in  <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= clr_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      rf_en    <= rf_en_nxt;
      rf_d_in  <= rf_d_nxt;
      clr_done <= clr_done_nxt;
    end
  end

`ifdef RFARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (ready[g] && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
    assign grant_cnt[g*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (NUM_REQ = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clr_req;
  logic        busy;
  logic        clr_done;
  logic [7:0]  rf_en;
  logic [31:0] rf_d_in;
`ifdef RFARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wr_arbiter_if #(.NUM_REQ(4)) bus ();

  regfile_wr_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_bus  (bus),
    .clr_req  (clr_req),
`ifdef RFARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .busy     (busy),
    .clr_done (clr_done),
    .rf_en    (rf_en),
    .rf_d_in  (rf_d_in)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    bus.req_addr[i*3 +: 3]   = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clr_req = 1'b0;
    bus.req_valid = 4'b0001; bus.req_addr = '0; bus.req_data = '0;
    #3;
    if (rf_en !== 8'h00) begin n_bad++; $display("FAIL reset_en got %h want 00", rf_en); end n_cmp++;
    if (rf_d_in !== 32'h0) begin n_bad++; $display("FAIL reset_d got %h want 0", rf_d_in); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end n_cmp++;
    if (clr_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", clr_done); end n_cmp++;
    if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end n_cmp++;
    bus.req_valid = '0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_single_write();
    set_req(0, 3'd5, 32'hDEADBEEF);
    bus.req_valid = 4'b0001;
    #1;
    if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", bus.req_ready); end n_cmp++;
    tick();
    bus.req_valid = 4'b0000;
    if (rf_en !== 8'h20) begin n_bad++; $display("FAIL single_en got %h want 20", rf_en); end n_cmp++;
    if (rf_d_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_d got %h want deadbeef", rf_d_in); end n_cmp++;
    tick();
    if (rf_en !== 8'h00) begin n_bad++; $display("FAIL single_en_off got %h want 00", rf_en); end n_cmp++;
    if (rf_d_in !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_d_hold got %h want deadbeef", rf_d_in); end n_cmp++;
  endtask

  // rr_ptr is 1 here; only requester 0 valid must wrap around to index 0.
  task automatic test_wrap_idle();
    set_req(0, 3'd3, 32'h12345678);
    bus.req_valid = 4'b0001;
    #1;
    if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL wrap_ready got %b want 0001", bus.req_ready); end n_cmp++;
    tick();
    bus.req_valid = 4'b0000;
    if (rf_en !== 8'h08) begin n_bad++; $display("FAIL wrap_en got %h want 08", rf_en); end n_cmp++;
    #1;
    if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_ready got %b want 0000", bus.req_ready); end n_cmp++;
    tick();
    if (rf_en !== 8'h00) begin n_bad++; $display("FAIL idle_en got %h want 00", rf_en); end n_cmp++;
    if (rf_d_in !== 32'h12345678) begin n_bad++; $display("FAIL idle_d_hold got %h want 12345678", rf_d_in); end n_cmp++;
  endtask

  task automatic test_fairness();
    logic [7:0] e;
    // Grant requester 3 alone first so rr_ptr returns to 0.
    set_req(3, 3'd0, 32'h33);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i + 1), 32'h100 + i);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus.req_ready !== 4'(1 << (k % 4))) begin n_bad++; $display("FAIL fair_ready%0d got %b want %b", k, bus.req_ready, 4'(1 << (k % 4))); end n_cmp++;
      tick();
      e = 8'd1 << ((k % 4) + 1);
      if (rf_en !== e) begin n_bad++; $display("FAIL fair_en%0d got %h want %h", k, rf_en, e); end n_cmp++;
      if (rf_d_in !== 32'h100 + (k % 4)) begin n_bad++; $display("FAIL fair_d%0d got %h want %h", k, rf_d_in, 32'h100 + (k % 4)); end n_cmp++;
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_clear();
    logic [7:0] e;
    set_req(1, 3'd6, 32'hAA);
    bus.req_valid = 4'b0010;
    clr_req = 1'b1;
    #1;
    if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL clr_prio_ready got %b want 0000", bus.req_ready); end n_cmp++;
    tick();
    clr_req = 1'b0;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_busy_start got %b want 1", busy); end n_cmp++;
    if (rf_en !== 8'h00) begin n_bad++; $display("FAIL clr_en_start got %h want 00", rf_en); end n_cmp++;
    for (int j = 0; j < 8; j++) begin
      tick();
      e = 8'd1 << j;
      if (rf_en !== e) begin n_bad++; $display("FAIL clr_en%0d got %h want %h", j, rf_en, e); end n_cmp++;
      if (rf_d_in !== 32'h0) begin n_bad++; $display("FAIL clr_d%0d got %h want 0", j, rf_d_in); end n_cmp++;
      if (clr_done !== (j == 7)) begin n_bad++; $display("FAIL clr_done%0d got %b want %b", j, clr_done, (j == 7)); end n_cmp++;
      if (busy !== (j != 7)) begin n_bad++; $display("FAIL clr_busy%0d got %b want %b", j, busy, (j != 7)); end n_cmp++;
      if (bus.req_ready !== ((j == 7) ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL clr_ready%0d got %b", j, bus.req_ready); end n_cmp++;
    end
    tick();
    bus.req_valid = 4'b0000;
    if (rf_en !== 8'h40) begin n_bad++; $display("FAIL clr_after_en got %h want 40", rf_en); end n_cmp++;
    if (rf_d_in !== 32'hAA) begin n_bad++; $display("FAIL clr_after_d got %h want aa", rf_d_in); end n_cmp++;
    if (clr_done !== 1'b0) begin n_bad++; $display("FAIL clr_done_pulse got %b want 0", clr_done); end n_cmp++;
  endtask

  task automatic test_clear_restart();
    int n = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      n++;
      clr_req = (c == 2);
      tick();
    end
    clr_req = 1'b0;
    if (n !== 8) begin n_bad++; $display("FAIL restart_len got %0d want 8", n); end n_cmp++;
    tick();
    if (busy !== 1'b0) begin n_bad++; $display("FAIL restart_busy got %b want 0", busy); end n_cmp++;
  endtask

  // rr_ptr is 2 before the reset; after it, requesters 1 and 3 contend and
  // 1 must win because the pointer is back at 0.
  task automatic test_reset_mid();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    if (rf_en !== 8'h04) begin n_bad++; $display("FAIL mid_pre_en got %h want 04", rf_en); end n_cmp++;
    set_req(1, 3'd2, 32'h11);
    set_req(3, 3'd7, 32'h33);
    bus.req_valid = 4'b1010;
    #2;
    reset_n = 1'b0;
    #1;
    if (rf_en !== 8'h00) begin n_bad++; $display("FAIL mid_en got %h want 00", rf_en); end n_cmp++;
    if (rf_d_in !== 32'h0) begin n_bad++; $display("FAIL mid_d got %h want 0", rf_d_in); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end n_cmp++;
    if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready got %b want 0000", bus.req_ready); end n_cmp++;
    tick();
    reset_n = 1'b1;
    #1;
    if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_ptr_ready got %b want 0010", bus.req_ready); end n_cmp++;
    tick();
    bus.req_valid = 4'b0000;
    if (rf_en !== 8'h04) begin n_bad++; $display("FAIL mid_grant_en got %h want 04", rf_en); end n_cmp++;
    if (rf_d_in !== 32'h11) begin n_bad++; $display("FAIL mid_grant_d got %h want 11", rf_d_in); end n_cmp++;
  endtask

`ifdef RFARB_STATS_EN
  task automatic test_stats();
    reset_n = 1'b0;
    #2;
    if (grant_cnt !== 64'h0) begin n_bad++; $display("FAIL stats_reset got %h want 0", grant_cnt); end n_cmp++;
    tick();
    reset_n = 1'b1;
    set_req(2, 3'd1, 32'h22);
    bus.req_valid = 4'b0100;
    repeat (70000) @(posedge clk);
    #1;
    bus.req_valid = 4'b0001;
    repeat (3) tick();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    if (grant_cnt[47:32] !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat got %h want ffff", grant_cnt[47:32]); end n_cmp++;
    if (grant_cnt[15:0] !== 16'd3) begin n_bad++; $display("FAIL stats_c0 got %h want 3", grant_cnt[15:0]); end n_cmp++;
    if (grant_cnt[31:16] !== 16'd1) begin n_bad++; $display("FAIL stats_c1 got %h want 1", grant_cnt[31:16]); end n_cmp++;
    if (grant_cnt[63:48] !== 16'd0) begin n_bad++; $display("FAIL stats_c3 got %h want 0", grant_cnt[63:48]); end n_cmp++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_wrap_idle();
    test_fairness();
    test_clear();
    test_clear_restart();
    test_reset_mid();
`ifdef RFARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
